// File: rtl/onewire_pkg.sv
// Shared types and default timing for the 1-Wire byte sequencer.
// Default slot timing matches Master_tx: 6-cycle write-1 low, 60-cycle write-0 low.
package onewire_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RST_LOW  = 3'd1,
        RST_WAIT = 3'd2,
        BIT_SLOT = 3'd3,
        RECOVER  = 3'd4
    } ow_state_e;

    localparam int MTX_WRITE1_LOW           = 6;
    localparam int MTX_WRITE0_LOW           = 60;

    localparam int DEF_SLOT_CYCLES          = 70;
    localparam int DEF_RECOVERY_CYCLES      = 2;
    localparam int DEF_RESET_LOW_CYCLES     = 480;
    localparam int DEF_RESET_RELEASE_CYCLES = 480;
    localparam int DEF_PRESENCE_SAMPLE      = 70;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int timer_width(input int slot, input int rec, input int rlow,
                                       input int rrel, input int psamp);
        int m;
        m = max2(max2(slot, rec), max2(max2(rlow, rrel), psamp));
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/onewire_slot_timer.sv
// Loadable down-counter shared by every timed state of the sequencer.
// expire_o is high while the count sits at zero, i.e. on the last cycle of a window.
module onewire_slot_timer #(
    parameter int CNT_W = 10
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic [CNT_W-1:0] value_o,
    output logic             expire_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign value_o  = cnt_q;
    assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/onewire_byte_sequencer.sv
// Command-level 1-Wire controller: optional reset/presence, then 8 bits LSB-first
// into Master_tx, with bit slots timed locally since Master_tx reports no completion.
module onewire_byte_sequencer
    import onewire_pkg::*;
#(
    parameter int SLOT_CYCLES          = DEF_SLOT_CYCLES,
    parameter int RECOVERY_CYCLES      = DEF_RECOVERY_CYCLES,
    parameter int RESET_LOW_CYCLES     = DEF_RESET_LOW_CYCLES,
    parameter int RESET_RELEASE_CYCLES = DEF_RESET_RELEASE_CYCLES,
    parameter int PRESENCE_SAMPLE      = DEF_PRESENCE_SAMPLE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_data,
    input  logic       cmd_reset,
    input  logic       bus_in,
    output logic       tx_bit,
    output logic       tx_ready,
    output logic       reset_drive_low,
    output logic       busy,
    output logic       done,
    output logic       presence,
    output logic       error
);

    localparam int CNT_W = timer_width(SLOT_CYCLES, RECOVERY_CYCLES, RESET_LOW_CYCLES,
                                       RESET_RELEASE_CYCLES, PRESENCE_SAMPLE);

    localparam logic [CNT_W-1:0] SLOT_LOAD = CNT_W'(SLOT_CYCLES - 1);
    localparam logic [CNT_W-1:0] REC_LOAD  = CNT_W'(RECOVERY_CYCLES - 1);
    localparam logic [CNT_W-1:0] RLOW_LOAD = CNT_W'(RESET_LOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] RREL_LOAD = CNT_W'(RESET_RELEASE_CYCLES - 1);
    // Timer counts down, so release-window index k corresponds to value RREL_LOAD-k.
    localparam logic [CNT_W-1:0] PSAMP_VAL = CNT_W'(RESET_RELEASE_CYCLES - 1 - PRESENCE_SAMPLE);

    ow_state_e        state_q, state_d;
    logic [7:0]       byte_q, byte_d;
    logic [2:0]       bit_q, bit_d;
    logic             presence_q, presence_d;
    logic             error_q, error_d;
    logic             done_q, done_d;

    logic             tmr_load;
    logic [CNT_W-1:0] tmr_load_val;
    logic [CNT_W-1:0] tmr_value;
    logic             tmr_expire;

    onewire_slot_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk_i      (clk),
        .rst_ni     (rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_load_val),
        .value_o    (tmr_value),
        .expire_o   (tmr_expire)
    );

    always_comb begin
        state_d      = state_q;
        byte_d       = byte_q;
        bit_d        = bit_q;
        presence_d   = presence_q;
        error_d      = error_q;
        done_d       = 1'b0;
        tmr_load     = 1'b0;
        tmr_load_val = SLOT_LOAD;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    byte_d   = cmd_data;
                    bit_d    = 3'd0;
                    error_d  = 1'b0;
                    tmr_load = 1'b1;
                    if (cmd_reset) begin
                        presence_d   = 1'b0;
                        tmr_load_val = RLOW_LOAD;
                        state_d      = RST_LOW;
                    end else begin
                        tmr_load_val = SLOT_LOAD;
                        state_d      = BIT_SLOT;
                    end
                end
            end
            RST_LOW: begin
                if (tmr_expire) begin
                    tmr_load     = 1'b1;
                    tmr_load_val = RREL_LOAD;
                    state_d      = RST_WAIT;
                end
            end
            RST_WAIT: begin
                if (tmr_value == PSAMP_VAL) begin
                    presence_d = ~bus_in;
                end
                if (tmr_expire) begin
                    // Decide on presence_d so a sample on the final window cycle still counts.
                    if (!presence_d) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        error_d = 1'b1;
                    end else begin
                        tmr_load     = 1'b1;
                        tmr_load_val = SLOT_LOAD;
                        state_d      = BIT_SLOT;
                    end
                end
            end
            BIT_SLOT: begin
                if (tmr_expire) begin
                    tmr_load     = 1'b1;
                    tmr_load_val = REC_LOAD;
                    state_d      = RECOVER;
                end
            end
            RECOVER: begin
                if (tmr_expire) begin
                    if (bit_q == 3'd7) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        bit_d        = bit_q + 3'd1;
                        tmr_load     = 1'b1;
                        tmr_load_val = SLOT_LOAD;
                        state_d      = BIT_SLOT;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            byte_q     <= 8'h00;
            bit_q      <= 3'd0;
            presence_q <= 1'b0;
            error_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_q     <= byte_d;
            bit_q      <= bit_d;
            presence_q <= presence_d;
            error_q    <= error_d;
            done_q     <= done_d;
        end
    end

    // Strobes decode straight from state so an asynchronous reset drops them at once.
    assign cmd_ready       = (state_q == IDLE);
    assign busy            = (state_q != IDLE);
    assign reset_drive_low = (state_q == RST_LOW);
    assign tx_ready        = (state_q == BIT_SLOT) && (tmr_value == SLOT_LOAD);
    assign tx_bit          = (state_q == BIT_SLOT) ? byte_q[bit_q] : 1'b0;
    assign done            = done_q;
    assign presence        = presence_q;
    assign error           = error_q;

endmodule

// File: doc/onewire_byte_sequencer.md
Name: onewire_byte_sequencer

Overview:
- Command-level controller for the 1-Wire master bit transmitter (Master_tx).
- Accepts one byte command at a time, optionally issues a bus reset/presence sequence, then feeds the 8 bits LSB-first into Master_tx.
- Times each bit slot itself, because Master_tx has no completion output.
- Sits between the host/register logic and Master_tx. Its reset_drive_low output is ANDed with the Master_tx bus_out at the top level.

Parameters:
- SLOT_CYCLES, 70, total cycles per bit slot. Must be greater than 60, the longest low time Master_tx produces (write-0).
- RECOVERY_CYCLES, 2, idle-high cycles between consecutive slots.
- RESET_LOW_CYCLES, 480, cycles the bus is held low for a reset pulse.
- RESET_RELEASE_CYCLES, 480, cycles after release before the first bit slot.
- PRESENCE_SAMPLE, 70, cycle index within the release window at which bus_in is sampled.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  high only in IDLE; a command is accepted when cmd_valid && cmd_ready.
- cmd_data  input  8  byte to transmit, LSB first.
- cmd_reset  input  1  when 1, a reset/presence sequence precedes the byte.
- bus_in  input  1  synchronized 1-Wire line level, used for presence detection.
- tx_bit  output  1  drives Master_tx bit_to_send.
- tx_ready  output  1  drives Master_tx ready; one-cycle pulse at the start of each slot.
- reset_drive_low  output  1  1 = force the bus low (reset pulse).
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse at the end of a command.
- presence  output  1  registered result of the last presence sample: 1 = device answered.
- error  output  1  valid with done: 1 = reset issued and no presence detected.

Behaviour:
- Reset (rst=0, asynchronous):
  - state = IDLE, counters = 0.
  - tx_bit=0, tx_ready=0, reset_drive_low=0, busy=0, done=0, presence=0, error=0, cmd_ready=1.
  - Asserting rst mid-operation aborts immediately: the bus is released, no done pulse is generated, and the latched byte is discarded.
- States: IDLE, RST_LOW, RST_WAIT, BIT_SLOT, RECOVER.
- IDLE:
  - On acceptance (cycle N), latch cmd_data, cmd_reset and bit index=0.
  - Cycle N+1 enters RST_LOW if cmd_reset=1, otherwise BIT_SLOT.
  - cmd_valid while busy is ignored; no queueing.
- RST_LOW:
  - reset_drive_low=1 for exactly RESET_LOW_CYCLES cycles, then RST_WAIT.
- RST_WAIT:
  - reset_drive_low=0; runs RESET_RELEASE_CYCLES cycles.
  - On cycle PRESENCE_SAMPLE (counted from 0), presence <= ~bus_in.
  - At window end, if presence=0: go to IDLE with done=1 and error=1; no bits are sent.
  - Otherwise go to BIT_SLOT.
- BIT_SLOT:
  - tx_bit = latched byte[bit index], held stable for the whole slot.
  - tx_ready=1 on the first slot cycle only.
  - Lasts SLOT_CYCLES cycles, then RECOVER.
- RECOVER:
  - tx_ready=0 for RECOVERY_CYCLES cycles.
  - If bit index=7: go to IDLE and pulse done=1, error=0.
  - Otherwise increment bit index and return to BIT_SLOT.
- Timing:
  - Byte time without reset = 8*(SLOT_CYCLES+RECOVERY_CYCLES).
  - done is asserted in the first IDLE cycle; cmd_ready is high that same cycle, so back-to-back commands are legal.
- Width rules:
  - Cycle counter width = $clog2(max of all timing parameters)+1.
  - Terminal comparisons are exact (count == PARAM-1); no wrap-around is reachable.
  - Bit index is 3 bits.
- Status hold:
  - presence and error hold until the next reset sequence or the next accepted command, respectively.
  - A command with cmd_reset=0 leaves presence unchanged.

Decomposition:
- Package onewire_pkg:
  - state enum (IDLE, RST_LOW, RST_WAIT, BIT_SLOT, RECOVER).
  - default timing constants, matching the 6-cycle write-1 and 60-cycle write-0 of Master_tx.
- One sub-module, onewire_slot_timer:
  - loadable down-counter with load, value and expire outputs.
  - Shared by all timed states.

Test Plan:
- Reset values: hold rst=0 for 3 cycles -> all outputs 0 except cmd_ready=1; bus idle-high at top level.
- Byte 0xA5 with cmd_reset=0:
  - tx_ready pulses 8 times, exactly 72 cycles apart.
  - tx_bit per slot = 1,0,1,0,0,1,0,1.
  - done=1 576 cycles after acceptance; error=0.
- Reset with device, cmd_reset=1, byte 0x3C, bus_in=0 at release cycle 70:
  - reset_drive_low high 480 cycles.
  - presence=1.
  - first tx_ready 960 cycles after the acceptance+1 cycle.
  - bits 0,0,1,1,1,1,0,0.
- No device, cmd_reset=1, bus_in=1 throughout:
  - done and error pulse 960 cycles after start.
  - presence=0.
  - zero tx_ready pulses.
- Busy-ignore and back-to-back:
  - cmd_valid held high with a new byte during a transfer -> not accepted until the done cycle.
  - Second byte starts one cycle later.
- Mid-operation reset:
  - Assert rst during bit 3 slot -> tx_ready, reset_drive_low, busy drop asynchronously.
  - No done pulse.
  - Next command transmits its full 8 bits.
